mc_connect_rr: RTL

- Parametrised N-to-1 memory request connector; successor to mc_connect.
- Sits between CONNECT_NUM slave request ports and one master memory port.
- Round-robin arbitration with a registered request output stage.
- Up to OUTSTANDING requests in flight; in-order responses are routed back to the originating port through a route-tag FIFO.

---
 rtl/mc_pkg.sv | 21 ++
 rtl/mc_route_fifo.sv | 61 ++++++
 rtl/mc_connect_rr.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and helpers for the mc_connect_rr request connector.
// Provides the default port-index type, the flat-bus lane offset helper and
// the round-robin pointer reset value. No ports (package only).
package mc_pkg;

  // Default port count; mc_connect_rr derives its own index width from its
  // CONNECT_NUM parameter, this typedef matches the default build.
  localparam int MC_CONNECT_NUM = 3;
  localparam int MC_IDX_WIDTH   = $clog2(MC_CONNECT_NUM);

  typedef logic [MC_IDX_WIDTH-1:0] mc_idx_t;

  // Port 0 has highest priority straight out of reset.
  localparam int MC_RR_RESET_PTR = 0;

  // Bit offset of lane 'lane' inside a flat bus of 'width'-bit lanes.
  function automatic int flat_slice(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mc_route_fifo.sv
// mc_route_fifo: small FIFO of port indices recording where each in-flight
//   request came from, so in-order responses can be steered back.
// Ports: CLK/RST (async active-low), push + push_idx, pop, full, empty, head.
//   Push while full and pop while empty are ignored; push+pop together keep count.
module mc_route_fifo
  import mc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_idx,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic do_push;
  logic do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/mc_connect_rr.sv
// mc_connect_rr: CONNECT_NUM-to-1 memory request connector with round-robin
//   arbitration, one registered request stage and a route-tag FIFO that steers
//   in-order responses back to the requesting port.
// Ports: SLAVE_RECEIVE_* (per-port requests in, one-hot READY), SLAVE_SEND_*
//   (per-port responses out), MASTER_SEND_* (registered request out),
//   MASTER_RECEIVE_* (responses in), ORPHAN_ERR (sticky orphan flag).
// Build option MC_CONNECT_ORPHAN_DROP_EN: responses arriving with nothing in
//   flight are accepted, dropped and flagged; otherwise they stall.
module mc_connect_rr
  import mc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int OUTSTANDING = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID,
  input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
  input  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY,
  output logic                              MASTER_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR,
  output logic                              MASTER_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA,
  input  logic                              MASTER_SEND_READY,
  input  logic                              MASTER_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA,
  output logic                              MASTER_RECEIVE_READY,
  output logic                              ORPHAN_ERR
);

  localparam int IDX_WIDTH = $clog2(CONNECT_NUM);
  localparam int LAST_PORT = CONNECT_NUM - 1;
  localparam logic [IDX_WIDTH:0]   NUM_EXT  = CONNECT_NUM[IDX_WIDTH:0];
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = LAST_PORT[IDX_WIDTH-1:0];
  localparam logic [IDX_WIDTH-1:0] RR_RST   = MC_RR_RESET_PTR[IDX_WIDTH-1:0];

  logic [IDX_WIDTH-1:0]   rr_ptr;
  logic [IDX_WIDTH-1:0]   gnt_idx;
  logic                   gnt_any;
  logic [IDX_WIDTH:0]     cand;
  logic                   slot_free;
  logic                   grant;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_dval;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [IDX_WIDTH-1:0]   fifo_head;
  logic                   fifo_pop;
  logic [CONNECT_NUM-1:0] head_hit;
  logic                   head_rdy;

  // ---------------------------------------------------------------- arbiter
  assign slot_free = !MASTER_SEND_ADDR_VALID || MASTER_SEND_READY;

  // First valid port searching upward from rr_ptr, wrapping at CONNECT_NUM.
  // cand is one bit wider so rr_ptr + k cannot overflow before the wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < CONNECT_NUM; k++) begin
      cand = {1'b0, rr_ptr} + k[IDX_WIDTH:0];
      if (cand >= NUM_EXT) cand = cand - NUM_EXT;
      if (!gnt_any && SLAVE_RECEIVE_ADDR_VALID[cand[IDX_WIDTH-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_WIDTH-1:0];
      end
    end
  end

  // A full FIFO blocks the grant even when a pop lands in the same cycle,
  // keeping the grant path independent of the response handshake.
  assign grant = RST && gnt_any && slot_free && !fifo_full;

  always_comb begin
    SLAVE_RECEIVE_READY = '0;
    sel_addr            = '0;
    sel_data            = '0;
    sel_dval            = 1'b0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (gnt_idx == i[IDX_WIDTH-1:0]) begin
        SLAVE_RECEIVE_READY[i] = grant;
        sel_addr = SLAVE_RECEIVE_ADDR[flat_slice(i, ADDR_WIDTH) +: ADDR_WIDTH];
        sel_data = SLAVE_RECEIVE_DATA[flat_slice(i, DATA_WIDTH) +: DATA_WIDTH];
        sel_dval = SLAVE_RECEIVE_DATA_VALID[i];
      end
    end
  end

  // ------------------------------------------------- registered request stage
  // Payload only moves on a grant, and a grant needs slot_free, so the
  // outputs stay put while the master stalls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MASTER_SEND_ADDR_VALID <= 1'b0;
      MASTER_SEND_ADDR       <= '0;
      MASTER_SEND_DATA_VALID <= 1'b0;
      MASTER_SEND_DATA       <= '0;
      rr_ptr                 <= RR_RST;
    end else if (grant) begin
      MASTER_SEND_ADDR_VALID <= 1'b1;
      MASTER_SEND_ADDR       <= sel_addr;
      MASTER_SEND_DATA_VALID <= sel_dval;
      MASTER_SEND_DATA       <= sel_data;
      rr_ptr                 <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end else if (MASTER_SEND_READY) begin
      MASTER_SEND_ADDR_VALID <= 1'b0;
    end
  end

  // --------------------------------------------------------- route tracking
  mc_route_fifo #(
    .WIDTH (IDX_WIDTH),
    .DEPTH (OUTSTANDING)
  ) u_route_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (grant),
    .push_idx (gnt_idx),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // ----------------------------------------------------------- response path
  always_comb begin
    head_hit = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      head_hit[i] = (fifo_head == i[IDX_WIDTH-1:0]);
    end
  end

  assign head_rdy         = |(SLAVE_SEND_READY & head_hit);
  assign SLAVE_SEND_VALID = (RST && MASTER_RECEIVE_VALID && !fifo_empty) ? head_hit : '0;
  assign SLAVE_SEND_DATA  = {CONNECT_NUM{MASTER_RECEIVE_DATA}};
  assign fifo_pop         = MASTER_RECEIVE_VALID && !fifo_empty && head_rdy;

`ifdef MC_CONNECT_ORPHAN_DROP_EN
  logic orphan_q;

  // With nothing in flight the response has no owner: swallow it.
  assign MASTER_RECEIVE_READY = RST && (fifo_empty || head_rdy);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      orphan_q <= 1'b0;
    end else if (MASTER_RECEIVE_VALID && fifo_empty) begin
      orphan_q <= 1'b1;
    end
  end

  assign ORPHAN_ERR = orphan_q;
`else
  // With nothing in flight the response waits until a request is issued.
  assign MASTER_RECEIVE_READY = RST && !fifo_empty && head_rdy;
  assign ORPHAN_ERR           = 1'b0;
`endif

endmodule
